// File: rtl/moving_sum_accum.sv
// rtl/moving_sum_accum.sv - recursive moving sum y[n] = y[n-1] + x[n] - x[n-N], N = len + 1, stream in/out.
// Optional 2-entry output skid buffer selected by MOVING_SUM_SKID_EN.
module moving_sum_accum #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        i_cur_tdata,
    input  logic [WIDTH-1:0]        i_dly_tdata,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [WIDTH+SIZE-1:0]   o_tdata,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    input  logic [SIZE-1:0]         len_data,
    input  logic                    len_valid,
    output logic                    o_busy
);

    localparam int OWIDTH = WIDTH + SIZE;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     len_q, len_d;
    logic [SIZE-1:0]     count_q, count_d;
    logic [OWIDTH-1:0]   acc_q, acc_d;
    logic [OWIDTH-1:0]   o_tdata_q, o_tdata_d;
    logic                o_tvalid_q, o_tvalid_d;

    logic [OWIDTH-1:0]   cur_ext;
    logic [OWIDTH-1:0]   dly_ext;
    logic [OWIDTH-1:0]   acc_upd;
    logic                accept;
    logic                emit;

    assign cur_ext = {{SIZE{i_cur_tdata[WIDTH-1]}}, i_cur_tdata};
    assign dly_ext = {{SIZE{i_dly_tdata[WIDTH-1]}}, i_dly_tdata};
    // Modulo arithmetic is fine: the window sum itself always fits OWIDTH.
    assign acc_upd = acc_q + cur_ext - dly_ext;
    assign accept  = i_tvalid & i_tready;

`ifdef MOVING_SUM_SKID_EN
    logic [OWIDTH-1:0]   skid_data_q, skid_data_d;
    logic                skid_valid_q, skid_valid_d;

    // Ready depends only on skid occupancy, never on o_tready.
    assign i_tready = ~reset & ~clear & ~len_valid & ~skid_valid_q;
`else
    assign i_tready = ~reset & ~clear & ~len_valid & (~o_tvalid_q | o_tready);
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
        emit    = 1'b0;
        if (clear) begin
            state_d = FILL;
            len_d   = '0;
            count_d = '0;
            acc_d   = '0;
        end else if (len_valid) begin
            state_d = FILL;
            len_d   = len_data;
            count_d = '0;
            acc_d   = '0;
        end else if (accept) begin
            acc_d = acc_upd;
            case (state_q)
                FILL: begin
                    if (count_q == len_q) begin
                        state_d = RUN;
                        emit    = 1'b1;
                    end else begin
                        count_d = count_q + SIZE'(1);
                    end
                end
                RUN: emit = 1'b1;
                default: state_d = FILL;
            endcase
        end
    end

`ifdef MOVING_SUM_SKID_EN
    always_comb begin
        o_tdata_d    = o_tdata_q;
        o_tvalid_d   = o_tvalid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (clear) begin
            o_tdata_d    = '0;
            o_tvalid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (len_valid) begin
            o_tvalid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (o_tready || !o_tvalid_q) begin
            // Output slot frees up: the older skid entry goes first to keep ordering.
            if (skid_valid_q) begin
                o_tdata_d    = skid_data_q;
                o_tvalid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (emit) begin
                o_tdata_d  = acc_upd;
                o_tvalid_d = 1'b1;
            end else begin
                o_tvalid_d = 1'b0;
            end
        end else if (emit) begin
            skid_data_d  = acc_upd;
            skid_valid_d = 1'b1;
        end
    end
`else
    always_comb begin
        o_tdata_d  = o_tdata_q;
        o_tvalid_d = o_tvalid_q;
        if (clear) begin
            o_tdata_d  = '0;
            o_tvalid_d = 1'b0;
        end else if (len_valid) begin
            o_tvalid_d = 1'b0;
        end else begin
            if (o_tready) begin
                o_tvalid_d = 1'b0;
            end
            if (emit) begin
                o_tdata_d  = acc_upd;
                o_tvalid_d = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            len_q      <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            o_tdata_q  <= '0;
            o_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            o_tdata_q  <= o_tdata_d;
            o_tvalid_q <= o_tvalid_d;
        end
    end

`ifdef MOVING_SUM_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`endif

    assign o_tdata  = o_tdata_q;
    assign o_tvalid = o_tvalid_q;
    assign o_busy   = (state_q == FILL);

endmodule

// File: tb/tb_moving_sum_accum.sv
// tb/tb_moving_sum_accum.sv - directed and randomised-backpressure checks for moving_sum_accum.
module tb_moving_sum_accum;

    localparam int WIDTH  = 16;
    localparam int SIZE   = 5;
    localparam int OWIDTH = WIDTH + SIZE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic [WIDTH-1:0]     i_cur_tdata;
    logic [WIDTH-1:0]     i_dly_tdata;
    logic                 i_tvalid;
    logic                 i_tready;
    logic [OWIDTH-1:0]    o_tdata;
    logic                 o_tvalid;
    logic                 o_tready;
    logic [SIZE-1:0]      len_data;
    logic                 len_valid;
    logic                 o_busy;

    logic                 rand_ready = 1'b0;
    logic                 ready_force = 1'b1;
    logic                 rnd_q = 1'b1;
    logic signed [31:0]   o_tdata_s;

    int checks = 0;
    int errors = 0;
    int got[$];
    int exp_q[$];
    int hist[$];
    logic                 prev_stall = 1'b0;
    logic [OWIDTH-1:0]    prev_data = '0;

    always #5 clk = ~clk;

    assign o_tready  = rand_ready ? rnd_q : ready_force;
    assign o_tdata_s = {{(32-OWIDTH){o_tdata[OWIDTH-1]}}, o_tdata};

    moving_sum_accum #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .i_cur_tdata(i_cur_tdata),
        .i_dly_tdata(i_dly_tdata),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .len_data   (len_data),
        .len_valid  (len_valid),
        .o_busy     (o_busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rnd_q = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && o_tvalid)
                check("hold_stable", o_tdata_s, {{(32-OWIDTH){prev_data[OWIDTH-1]}}, prev_data});
            if (o_tvalid && o_tready)
                got.push_back(o_tdata_s);
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int cur, input int dly);
        int n;
        n = 0;
        i_cur_tdata = cur[WIDTH-1:0];
        i_dly_tdata = dly[WIDTH-1:0];
        i_tvalid    = 1'b1;
        @(negedge clk);
        while (!i_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500)
            check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic load_len(input int len);
        len_data  = len[SIZE-1:0];
        len_valid = 1'b1;
        i_tvalid  = 1'b1;
        @(negedge clk);
        check("len_cycle_tready", i_tready, 0);
        @(posedge clk);
        #1;
        len_valid = 1'b0;
        i_tvalid  = 1'b0;
    endtask

    initial begin
        int exp1[7];
        int cur, dly, s, n_win, t;
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; len_valid = 1'b0;
        i_cur_tdata = '0; i_dly_tdata = '0; len_data = '0;
        wait_cycles(2);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata_s, 0);
        check("rst_busy", o_busy, 1);
        check("rst_tready", i_tready, 0);
        reset = 1'b0;
        #1;
        check("tready_after_rst", i_tready, 1);
        wait_cycles(1);

        // len=3: N=4 window over 1..10
        load_len(3);
        got.delete();
        for (int i = 1; i <= 10; i++) send(i, (i > 4) ? i - 4 : 0);
        wait_cycles(3);
        exp1 = '{10, 14, 18, 22, 26, 30, 34};
        check("t1_count", got.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < got.size()) check($sformatf("t1_out%0d", i), got[i], exp1[i]);

        // len=0: pass-through
        load_len(0);
        got.delete();
        check("t2_busy_before", o_busy, 1);
        send(-5, 0);
        check("t2_busy_after", o_busy, 0);
        send(7, -5);
        send(32767, 7);
        wait_cycles(3);
        check("t2_count", got.size(), 3);
        if (got.size() == 3) begin
            check("t2_out0", got[0], -5);
            check("t2_out1", got[1], 7);
            check("t2_out2", got[2], 32767);
        end

        // len=31: full-scale window
        load_len(31);
        got.delete();
        for (int i = 0; i < 40; i++) send(32767, (i >= 32) ? 32767 : 0);
        wait_cycles(3);
        check("t3_count", got.size(), 9);
        for (int i = 0; i < got.size(); i++) check($sformatf("t3_out%0d", i), got[i], 1048544);

        // len_valid while an output is stalled
        load_len(3);
        ready_force = 1'b0;
        got.delete();
        send(5, 0); send(6, 0); send(7, 0); send(8, 0);
        check("t5_pending", o_tvalid, 1);
        check("t5_pending_data", o_tdata_s, 26);
        load_len(3);
        check("t5_dropped", o_tvalid, 0);
        check("t5_busy", o_busy, 1);
        ready_force = 1'b1;
        send(1, 0); send(2, 0); send(3, 0);
        wait_cycles(2);
        check("t5_no_out_fill", got.size(), 0);
        send(4, 0);
        wait_cycles(2);
        check("t5_count", got.size(), 1);
        if (got.size() == 1) check("t5_out", got[0], 10);

        // asynchronous reset while an output is stalled
        load_len(1);
        ready_force = 1'b0;
        send(3, 0); send(4, 0);
        check("t6_pending", o_tvalid, 1);
        check("t6_pending_data", o_tdata_s, 7);
        reset = 1'b1;
        #1;
        check("t6_async_tvalid", o_tvalid, 0);
        check("t6_async_tdata", o_tdata_s, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_force = 1'b1;
        got.delete();
        check("t6_busy", o_busy, 1);
        send(9, 0);
        wait_cycles(2);
        check("t6_count", got.size(), 1);
        if (got.size() == 1) check("t6_out", got[0], 9);

        // clear and len_valid together: clear wins, len back to 0
        load_len(3);
        clear = 1'b1; len_valid = 1'b1; len_data = 5'd5;
        wait_cycles(1);
        clear = 1'b0; len_valid = 1'b0;
        check("t7_busy", o_busy, 1);
        got.delete();
        send(11, 0);
        wait_cycles(2);
        check("t7_count", got.size(), 1);
        if (got.size() == 1) check("t7_out", got[0], 11);

        // random backpressure against a windowed-sum model
        n_win = 8;
        load_len(n_win - 1);
        got.delete(); exp_q.delete(); hist.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cur = int'($urandom_range(0, 65535)) - 32768;
            dly = (i >= n_win) ? hist[i - n_win] : 0;
            hist.push_back(cur);
            send(cur, dly);
            if (i >= n_win - 1) begin
                s = 0;
                for (int k = i - n_win + 1; k <= i; k++) s += hist[k];
                exp_q.push_back(s);
            end
        end
        t = 0;
        while (got.size() < exp_q.size() && t < 2000) begin
            wait_cycles(1);
            t++;
        end
        rand_ready = 1'b0;
        wait_cycles(3);
        check("t4_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("t4_out%0d", i), got[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
